// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling constants and baud divider helper.
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * UART_OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-cycle tick every DIV clocks, synchronous clear.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled 8N1 receiver with one-cycle data_valid/frame_error strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_busy
);
  localparam int DIV = uart_div(CLK_HZ, BAUD);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
  logic par_bad;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif
  uart_rx_state_t state, state_n;
  logic rx_m, rx_s, tick, clear, mid;
  logic [3:0] scnt;
  logic [2:0] bcnt;
  logic [7:0] shift;
  uart_baud_tick #(.DIV(DIV)) u_tick (.clock(clock), .reset(reset), .clear(clear), .tick(tick));
  assign rx_busy = state != IDLE;
  // mid: the tick that lands on the current state's sample point (half bit in START, full bit elsewhere)
  assign mid = tick && scnt == ((state == START) ? 4'(UART_OVERSAMPLE / 2 - 1) : 4'(UART_OVERSAMPLE - 1));
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    clear = 1'b0;
    unique case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        clear = 1'b1;
      end
      START:  if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:   if (mid && bcnt == 3'(UART_DATA_BITS - 1)) state_n = AFTER_DATA;
      PARITY: if (mid) state_n = STOP;
      STOP:   if (mid) state_n = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {rx_m, rx_s} <= 2'b11;
      scnt <= '0;
      bcnt <= '0;
      shift <= '0;
      data <= '0;
      data_valid <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      {rx_m, rx_s} <= {UART_RX, rx_m};
      data_valid <= 1'b0;
      frame_error <= 1'b0;
      // a completing tick is consumed by the state change, so the next state counts from zero
      scnt <= (state_n != state) ? '0 : scnt + {3'b0, tick};
      if (state == START) bcnt <= '0;
      if (state == DATA && mid) begin
        shift <= {rx_s, shift[7:1]};
        bcnt <= bcnt + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
      if (state == PARITY && mid) par_bad <= ^{shift, rx_s};
      if (state == STOP && mid) begin
        frame_error <= !rx_s;
        parity_error <= rx_s && par_bad;
        data_valid <= rx_s && !par_bad;
        if (rx_s && !par_bad) data <= shift;
      end
`else
      if (state == STOP && mid) begin
        frame_error <= !rx_s;
        data_valid <= rx_s;
        if (rx_s) data <= shift;
      end
`endif
    end
endmodule
